// File: rtl/cache_arbiter.sv
// Shares one pmem port between I-cache and D-cache: round-robin on ties, strobes rise the cycle after grant.
// Requesters hold level requests until their 1-cycle resp; a granted transfer runs to mem_resp regardless.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] wdata;
  } req_t;

  state_t state;
  state_t state_nxt;
  req_t   lat_req;
  req_t   i_req_dat;
  req_t   d_req_dat;

  logic prio_d;
  logic i_req;
  logic d_req;
  logic granting;
  logic tie;
  logic grant_i;
  logic grant_d;
  logic in_grant;

  assign i_req     = i_read | i_write;
  assign d_req     = d_read | d_write;
  assign granting  = (state == IDLE) || (state == RELEASE);
  assign tie       = granting && i_req && d_req;
  assign grant_i   = granting && i_req && (!d_req || !prio_d);
  assign grant_d   = granting && d_req && (!i_req ||  prio_d);

  // A simultaneous read and write from one cache is carried out as a write.
  assign i_req_dat = {i_write, i_address, i_wdata};
  assign d_req_dat = {d_write, d_address, d_wdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RELEASE: begin
        if (grant_i) begin
          state_nxt = GRANT_I;
        end else if (grant_d) begin
          state_nxt = GRANT_D;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_resp) begin
          state_nxt = RELEASE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // prio_d set means D wins the next tie; D therefore wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_req        <= '0;
      prio_d         <= 1'b1;
      conflict_count <= '0;
    end else begin
      if (grant_i) begin
        lat_req <= i_req_dat;
        prio_d  <= 1'b1;
      end else if (grant_d) begin
        lat_req <= d_req_dat;
        prio_d  <= 1'b0;
      end
      if (tie && (conflict_count != {CNT_WIDTH{1'b1}})) begin
        conflict_count <= conflict_count + CNT_WIDTH'(1);
      end
    end
  end

  assign in_grant = (state == GRANT_I) || (state == GRANT_D);

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    busy      = (state != IDLE);
    if (in_grant) begin
      mem_read  = !lat_req.write;
      mem_write =  lat_req.write;
    end
    if (state == GRANT_I) begin
      i_resp = mem_resp;
    end
    if (state == GRANT_D) begin
      d_resp = mem_resp;
    end
  end

  assign mem_address = lat_req.addr;
  assign mem_wdata   = lat_req.wdata;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a scoreboard queue of expected grants, checked by a monitor
// at each strobe rise and resp pulse, plus a behavioural pmem responder.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_read, i_write, d_read, d_write;
  logic [15:0]  i_address, d_address;
  logic [127:0] i_wdata, d_wdata;
  logic         i_resp, d_resp;
  logic [127:0] i_rdata, d_rdata;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;
  logic         busy;
  logic [1:0]   conflict_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit           side_d;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   cur_vld = 1'b0;

  int mem_lat    = 5;
  bit resp_en    = 1'b1;
  bit force_resp = 1'b0;

  cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .CNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .busy(busy), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit side_d, input bit wr, input logic [15:0] addr, input logic [127:0] wdata);
    exp_t e;
    e.side_d = side_d;
    e.wr     = wr;
    e.addr   = addr;
    e.wdata  = wdata;
    exp_q.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a resp pulse, then returns just after the following edge.
  task automatic wait_resp(output bit got_i, output bit got_d);
    got_i = 1'b0;
    got_d = 1'b0;
    for (int k = 0; k < 60 && !(got_i || got_d); k++) begin
      @(negedge clk);
      got_i = i_resp;
      got_d = d_resp;
    end
    chk("resp_seen", got_i | got_d, 1'b1);
    step();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(negedge clk);
    step();
    reset = 1'b0;
  endtask

  // pmem model: responds in the mem_lat-th strobe cycle with the address replicated as data.
  initial begin
    int cnt = 0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      step();
      if (resp_en) begin
        if (mem_read || mem_write) begin
          cnt++;
          mem_resp = (cnt == mem_lat);
          if (cnt == mem_lat) mem_rdata = {8{mem_address}};
        end else begin
          cnt      = 0;
          mem_resp = 1'b0;
        end
      end else begin
        cnt      = 0;
        mem_resp = force_resp;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    bit prev = 1'b0;
    bit strobe;
    forever begin
      @(negedge clk);
      if (reset) begin
        cur_vld = 1'b0;
        prev    = 1'b0;
      end else begin
        strobe = mem_read | mem_write;
        if (strobe && !prev) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant: got addr %h expected no grant", mem_address);
          end else begin
            cur     = exp_q.pop_front();
            cur_vld = 1'b1;
            chk("grant_write", mem_write, cur.wr);
            chk("grant_read", mem_read, !cur.wr);
            chk("grant_addr", mem_address, cur.addr);
            if (cur.wr) chk("grant_wdata", mem_wdata, cur.wdata);
          end
        end
        if (i_resp || d_resp) begin
          if (!cur_vld) begin
            total++;
            bad++;
            $display("FAIL stray_resp: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
          end else begin
            chk("resp_i", i_resp, !cur.side_d);
            chk("resp_d", d_resp, cur.side_d);
            chk("rdata", cur.side_d ? d_rdata : i_rdata, {8{cur.addr}});
            cur_vld = 1'b0;
          end
        end
        prev = strobe;
      end
    end
  end

  initial begin
    bit gi, gd;
    reset = 1'b1;
    i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_count", conflict_count, 0);
    step();
    reset = 1'b0;

    // 1: I-only read, one-cycle grant latency, RELEASE then IDLE
    step();
    i_read = 1; i_address = 16'h1230;
    push(0, 0, 16'h1230, '0);
    @(negedge clk);
    chk("t1_no_strobe_yet", mem_read, 0);
    @(negedge clk);
    chk("t1_mem_read", mem_read, 1);
    chk("t1_addr", mem_address, 16'h1230);
    chk("t1_busy", busy, 1);
    wait_resp(gi, gd);
    chk("t1_i_side", {gi, gd}, 2'b10);
    i_read = 0;
    @(negedge clk);
    chk("t1_release_strobe", mem_read | mem_write, 0);
    chk("t1_release_busy", busy, 1);
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);

    // 2: simultaneous requests from reset, D first, then I after a one-cycle gap
    do_reset();
    i_read = 1; i_address = 16'h0040;
    d_write = 1; d_address = 16'h8000; d_wdata = {16{8'h3C}};
    push(1, 1, 16'h8000, {16{8'h3C}});
    push(0, 0, 16'h0040, '0);
    wait_resp(gi, gd);
    d_write = 0;
    @(negedge clk);
    chk("t2_gap", mem_read | mem_write, 0);
    @(negedge clk);
    chk("t2_i_granted", mem_read, 1);
    wait_resp(gi, gd);
    i_read = 0;
    chk("t2_count", conflict_count, 1);

    // 3: both hold requests; order D,I,D,I; 2-bit counter saturates
    i_read = 1; i_address = 16'h0100;
    d_read = 1; d_address = 16'h0200;
    push(1, 0, 16'h0200, '0);
    push(0, 0, 16'h0100, '0);
    push(1, 0, 16'h0210, '0);
    push(0, 0, 16'h0110, '0);
    wait_resp(gi, gd);
    d_address = 16'h0210;
    wait_resp(gi, gd);
    i_address = 16'h0110;
    wait_resp(gi, gd);
    d_read = 0;
    wait_resp(gi, gd);
    i_read = 0;
    chk("t3_count_sat", conflict_count, 3);

    // 4: D writeback data is latched at grant
    do_reset();
    d_write = 1; d_address = 16'h2000; d_wdata = {16{8'hA5}};
    push(1, 1, 16'h2000, {16{8'hA5}});
    @(negedge clk);
    @(negedge clk);
    chk("t4_mem_write", mem_write, 1);
    chk("t4_no_read", mem_read, 0);
    chk("t4_wdata", mem_wdata, {16{8'hA5}});
    step();
    d_wdata = {16{8'h5A}};
    @(negedge clk);
    chk("t4_wdata_held", mem_wdata, {16{8'hA5}});
    wait_resp(gi, gd);
    d_write = 0;

    // 5: requester drops d_read mid-grant; transfer still completes and pulses d_resp
    mem_lat = 6;
    step();
    d_read = 1; d_address = 16'h3000;
    push(1, 0, 16'h3000, '0);
    @(negedge clk);
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    d_read = 0;
    @(negedge clk);
    chk("t5_read_held", mem_read, 1);
    step();
    @(negedge clk);
    chk("t5_read_held2", mem_read, 1);
    wait_resp(gi, gd);
    chk("t5_d_resp", gd, 1);

    // 6: reset mid-grant drops strobe at once; stray mem_resp afterwards is ignored
    resp_en = 0;
    step();
    i_read = 1; i_address = 16'h4000;
    push(0, 0, 16'h4000, '0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_granted", mem_read, 1);
    step();
    reset = 1; i_read = 0; force_resp = 1;
    @(negedge clk);
    chk("t6_strobe_drop", mem_read, 0);
    chk("t6_busy_drop", busy, 0);
    chk("t6_count_clr", conflict_count, 0);
    chk("t6_no_i_resp_rst", i_resp, 0);
    step();
    reset = 0;
    step();
    @(negedge clk);
    chk("t6_stray_i_resp", i_resp, 0);
    chk("t6_stray_d_resp", d_resp, 0);
    chk("t6_idle", busy, 0);
    step();
    force_resp = 0;
    step();

    chk("queue_empty", exp_q.size(), 0);
    chk("no_open_xfer", cur_vld, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
